// File: rtl/tetris_pkg.sv
// tetris_pkg: shared game types and default timing constants
package tetris_pkg;
    typedef enum logic [1:0] {IDLE, FALL, LAND, PAUSE} gravity_state_e;
    localparam int DEF_CNT_W       = 26;
    localparam int DEF_BASE_PERIOD = 33554432;
    localparam int DEF_MIN_PERIOD  = 1048576;
    localparam int DEF_SOFT_PERIOD = 2500000;
    localparam int DEF_LOCK_DELAY  = 25000000;
    localparam int DEF_MAX_RESETS  = 15;
endpackage

// File: rtl/gravity_scheduler_if.sv
// gravity_scheduler_if: controller-side handshake bundle of the gravity scheduler
interface gravity_scheduler_if
    import tetris_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();
    logic             spawn;
    logic             pause;
    logic [3:0]       level;
    logic             soft_drop;
    logic             landed;
    logic             move_reset;
    logic             drop_tick;
    logic             lock_tick;
    gravity_state_e   state;
    logic [CNT_W-1:0] cur_period;
    modport master (
        output spawn, pause, level, soft_drop, landed, move_reset,
        input  drop_tick, lock_tick, state, cur_period
    );
    modport slave (
        input  spawn, pause, level, soft_drop, landed, move_reset,
        output drop_tick, lock_tick, state, cur_period
    );
endinterface

// File: rtl/gravity_period_sel.sv
// gravity_period_sel: level/soft_drop to drop period, floored at MIN_PERIOD
module gravity_period_sel #(
    parameter int CNT_W       = 26,
    parameter int BASE_PERIOD = 33554432,
    parameter int MIN_PERIOD  = 1048576,
    parameter int SOFT_PERIOD = 2500000
) (
    input  logic [3:0]       level,
    input  logic             soft_drop,
    output logic [CNT_W-1:0] cur_period
);
    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] SOFT = CNT_W'(SOFT_PERIOD);
    logic [CNT_W-1:0] shifted, lvl_p;
    always_comb begin
        shifted    = BASE >> level;
        lvl_p      = shifted > MINP ? shifted : MINP;
        cur_period = soft_drop && SOFT < lvl_p ? SOFT : lvl_p;
    end
endmodule

// File: rtl/gravity_scheduler.sv
// gravity_scheduler: level-paced drop ticks and lock-delay timer for the falling piece
module gravity_scheduler
    import tetris_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int SOFT_PERIOD = DEF_SOFT_PERIOD,
    parameter int LOCK_DELAY  = DEF_LOCK_DELAY,
    parameter int MAX_RESETS  = DEF_MAX_RESETS
) (
    input logic clk,
    input logic reset,
    gravity_scheduler_if.slave bus
);
    localparam int RU_W = $clog2(MAX_RESETS + 2);
    localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(LOCK_DELAY - 1);
    localparam logic [RU_W-1:0]  RU_MAX   = RU_W'(MAX_RESETS);
    gravity_state_e   state, state_nxt, saved, saved_nxt;
    logic [CNT_W-1:0] g_cnt, g_nxt, l_cnt, l_nxt, cur_period, g_inc, l_inc;
    logic [RU_W-1:0]  ru, ru_nxt;
    logic             drop_q, drop_nxt, lock_q, lock_nxt;
    logic             g_end, l_end, can_reset;
    gravity_period_sel #(
        .CNT_W(CNT_W), .BASE_PERIOD(BASE_PERIOD),
        .MIN_PERIOD(MIN_PERIOD), .SOFT_PERIOD(SOFT_PERIOD)
    ) u_period (
        .level(bus.level), .soft_drop(bus.soft_drop), .cur_period(cur_period)
    );
    assign g_inc     = &g_cnt ? g_cnt : g_cnt + CNT_W'(1);
    assign l_inc     = &l_cnt ? l_cnt : l_cnt + CNT_W'(1);
    assign g_end     = g_cnt >= cur_period - CNT_W'(1);
    assign l_end     = l_cnt >= LOCK_END;
    assign can_reset = bus.move_reset && ru < RU_MAX;
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            saved  <= IDLE;
            g_cnt  <= '0;
            l_cnt  <= '0;
            ru     <= '0;
            drop_q <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            saved  <= saved_nxt;
            g_cnt  <= g_nxt;
            l_cnt  <= l_nxt;
            ru     <= ru_nxt;
            drop_q <= drop_nxt;
            lock_q <= lock_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = bus.spawn ? FALL : IDLE;
        else if (state == PAUSE) state_nxt = bus.pause ? PAUSE : saved;
        else if (bus.pause) state_nxt = PAUSE;
        else if (bus.spawn) state_nxt = FALL;
        else if (state == FALL) state_nxt = bus.landed ? LAND : FALL;
        else if (!bus.landed) state_nxt = FALL;
        else if (!can_reset && l_end) state_nxt = IDLE;
    end
    // Counter updates follow the same priority as the state decision: pause, spawn, landed/move, timers.
    always_comb begin
        g_nxt     = g_cnt;
        l_nxt     = l_cnt;
        ru_nxt    = ru;
        saved_nxt = saved;
        drop_nxt  = 1'b0;
        lock_nxt  = 1'b0;
        if (state == IDLE) begin
            g_nxt  = '0;
            l_nxt  = '0;
            ru_nxt = '0;
        end else if (state != PAUSE) begin
            if (bus.pause) saved_nxt = state;
            else if (bus.spawn) begin
                g_nxt  = '0;
                l_nxt  = '0;
                ru_nxt = '0;
            end else if (state == FALL) begin
                if (bus.landed) l_nxt = '0;
                else if (g_end) begin
                    g_nxt    = '0;
                    drop_nxt = 1'b1;
                end else g_nxt = g_inc;
            end else if (!bus.landed) g_nxt = '0;
            else if (can_reset) begin
                l_nxt  = '0;
                ru_nxt = ru + RU_W'(1);
            end else if (l_end) begin
                l_nxt    = '0;
                lock_nxt = 1'b1;
            end else l_nxt = l_inc;
        end
    end
    assign bus.drop_tick  = drop_q;
    assign bus.lock_tick  = lock_q;
    assign bus.state      = state;
    assign bus.cur_period = cur_period;
endmodule

// File: tb/tb_gravity_scheduler.sv
// tb_gravity_scheduler: directed scenarios plus random traffic against a cycle-level reference model
module tb_gravity_scheduler;
    import tetris_pkg::*;
    localparam int CW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    gravity_scheduler_if #(.CNT_W(CW)) bus ();
    gravity_scheduler #(
        .CNT_W(CW), .BASE_PERIOD(64), .MIN_PERIOD(4),
        .SOFT_PERIOD(8), .LOCK_DELAY(20), .MAX_RESETS(2)
    ) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // Reference state: 0 idle, 1 falling, 2 landed, 3 paused
    int m_state = 0, m_saved = 0, m_g = 0, m_l = 0, m_ru = 0;
    int m_drop = 0, m_lock = 0;
    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int period(input int lv, input int sd);
        int p;
        p = 64 >> lv;
        if (p < 4) p = 4;
        if (sd != 0 && p > 8) p = 8;
        return p;
    endfunction
    task automatic model_step();
        int p;
        p = period(int'(bus.level), int'(bus.soft_drop));
        m_drop = 0;
        m_lock = 0;
        if (reset) begin
            m_state = 0; m_g = 0; m_l = 0; m_ru = 0; m_saved = 0;
        end else if (m_state == 0) begin
            if (bus.spawn) begin m_state = 1; m_g = 0; m_ru = 0; end
        end else if (m_state == 3) begin
            if (!bus.pause) m_state = m_saved;
        end else if (bus.pause) begin
            m_saved = m_state; m_state = 3;
        end else if (bus.spawn) begin
            m_state = 1; m_g = 0; m_l = 0; m_ru = 0;
        end else if (m_state == 1) begin
            if (bus.landed) begin m_state = 2; m_l = 0; end
            else if (m_g + 1 >= p) begin m_drop = 1; m_g = 0; end
            else m_g++;
        end else begin
            if (!bus.landed) begin m_state = 1; m_g = 0; end
            else if (bus.move_reset && m_ru < 2) begin m_l = 0; m_ru++; end
            else if (m_l == 19) begin m_lock = 1; m_state = 0; m_l = 0; end
            else m_l++;
        end
    endtask
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("drop", int'(bus.drop_tick), m_drop);
        chk("lock", int'(bus.lock_tick), m_lock);
        chk("state", int'(bus.state), m_state);
        chk("period", int'(bus.cur_period), period(int'(bus.level), int'(bus.soft_drop)));
    endtask
    task automatic run_until_drop(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (bus.drop_tick) begin n = i; break; end
        end
    endtask
    task automatic run_until_lock(output int n, output int drops);
        n = -1;
        drops = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (bus.drop_tick) drops++;
            if (bus.lock_tick) begin n = i; break; end
        end
    endtask
    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask
    initial begin
        int n, d, acc;
        bus.spawn = 0; bus.pause = 0; bus.level = 0; bus.soft_drop = 0;
        bus.landed = 0; bus.move_reset = 0;
        steps(2);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_drop", int'(bus.drop_tick), 0);
        reset = 0;
        steps(3);
        // gravity at level 0
        bus.spawn = 1; step(); bus.spawn = 0;
        run_until_drop(n); chk("t1_first", n, 64);
        run_until_drop(n); chk("t1_second", n, 64);
        run_until_drop(n); chk("t1_third", n, 64);
        // level and soft drop periods
        bus.level = 5;
        run_until_drop(n); chk("t2_lvl5_a", n, 4);
        chk("t2_p5", int'(bus.cur_period), 4);
        run_until_drop(n); chk("t2_lvl5_b", n, 4);
        bus.level = 3; bus.soft_drop = 1; step();
        chk("t2_soft_p", int'(bus.cur_period), 8);
        bus.level = 0; bus.soft_drop = 0;
        run_until_drop(n);
        steps(10);
        bus.soft_drop = 1;
        run_until_drop(n); chk("t2_past_end", n, 1);
        run_until_drop(n); chk("t2_soft_period", n, 8);
        bus.soft_drop = 0;
        // landing then lock
        run_until_drop(n);
        steps(30);
        bus.landed = 1; step();
        run_until_lock(n, d);
        chk("t3_lock", n, 20);
        chk("t3_no_drop", d, 0);
        chk("t3_idle", int'(bus.state), 0);
        bus.landed = 0; step();
        // lock-delay restarts
        bus.spawn = 1; step(); bus.spawn = 0;
        bus.landed = 1; step();
        steps(10);
        bus.move_reset = 1; step(); bus.move_reset = 0;
        steps(9);
        bus.move_reset = 1; step(); bus.move_reset = 0;
        steps(9);
        bus.move_reset = 1; step(); bus.move_reset = 0;
        acc = 10;
        run_until_lock(n, d);
        chk("t4_lock_after_2nd", acc + n, 20);
        bus.landed = 0; step();
        // pause and resume
        bus.spawn = 1; step(); bus.spawn = 0;
        steps(40);
        bus.pause = 1;
        d = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.drop_tick || bus.lock_tick) d++;
        end
        chk("t5_no_pulse", d, 0);
        chk("t5_paused", int'(bus.state), 3);
        bus.pause = 0; step();
        run_until_drop(n); chk("t5_resume", n, 24);
        // reset in the middle of a landing
        bus.landed = 1; steps(6);
        reset = 1; step(); reset = 0;
        chk("t5_rst_state", int'(bus.state), 0);
        chk("t5_rst_lock", int'(bus.lock_tick), 0);
        bus.landed = 0; step();
        // random traffic
        for (int c = 0; c < 4000; c++) begin
            bus.spawn = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) bus.pause = ~bus.pause;
            if ($urandom_range(0, 59) == 0) bus.level = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) bus.soft_drop = ~bus.soft_drop;
            if ($urandom_range(0, 44) == 0) bus.landed = ~bus.landed;
            bus.move_reset = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 799) == 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
